// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: fetch presents a beat, decode reports whether it takes it.
interface decode_stage_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        de_ready;

  modport master (
    output if_valid,
    output if_pc,
    output if_insn,
    input  de_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_insn,
    output de_ready
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: holding register H feeds combinational decode and operand select,
// output register O carries the decoded payload to execute.
module decode_stage (
  input  logic          clk,
  input  logic          reset_n,
  decode_stage_if.slave fetch,
  output logic [4:0]    de_rs1,
  output logic [4:0]    de_rs2,
  input  logic [31:0]   rf_rdata1,
  input  logic [31:0]   rf_rdata2,
  input  logic          fwd_stall,
  input  logic [1:0]    fwd_rs1,
  input  logic [1:0]    fwd_rs2,
  input  logic [31:0]   ex_fwd_data,
  input  logic [31:0]   mem_fwd_data,
  input  logic          ex_ready,
  input  logic          flush,
  output logic          ex_valid_o,
  output logic [31:0]   ex_pc,
  output logic [4:0]    ex_rd,
  output logic [31:0]   ex_op1,
  output logic [31:0]   ex_op2,
  output logic [31:0]   ex_imm,
  output logic [6:0]    ex_opcode,
  output logic [2:0]    ex_funct3,
  output logic          ex_funct7b5,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_reg_write,
  output logic          ex_illegal
);

  // fwd_rs1/fwd_rs2 bit positions: {ex, mem}
  localparam int unsigned FwdEx  = 1;
  localparam int unsigned FwdMem = 0;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } payload_t;

  logic        h_valid_q, h_valid_d;
  logic [31:0] h_pc_q, h_pc_d;
  logic [31:0] h_insn_q, h_insn_d;
  logic        o_valid_q, o_valid_d;
  payload_t    o_q, o_d;

  logic        out_free;
  logic        advance;
  logic        accept;

  logic        use_rs1, use_rs2, use_rd;
  logic        is_load, is_store, is_illegal;
  logic [31:0] imm;
  logic [6:0]  opc;
  payload_t    dec;

  assign opc = h_insn_q[6:0];

  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_illegal = 1'b0;
    imm        = 32'h0;
    case (opc)
      OpcLui, OpcAuipc: begin
        use_rd = 1'b1;
        imm    = {h_insn_q[31:12], 12'h000};
      end
      OpcJal: begin
        use_rd = 1'b1;
        imm    = {{12{h_insn_q[31]}}, h_insn_q[19:12], h_insn_q[20], h_insn_q[30:21], 1'b0};
      end
      OpcJalr, OpcOpImm: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm     = {{21{h_insn_q[31]}}, h_insn_q[30:20]};
      end
      OpcLoad: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        is_load = 1'b1;
        imm     = {{21{h_insn_q[31]}}, h_insn_q[30:20]};
      end
      OpcBranch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{h_insn_q[31]}}, h_insn_q[7], h_insn_q[30:25], h_insn_q[11:8], 1'b0};
      end
      OpcStore: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        is_store = 1'b1;
        imm      = {{21{h_insn_q[31]}}, h_insn_q[30:25], h_insn_q[11:7]};
      end
      OpcOp: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OpcFence, OpcSystem: begin
        imm = {{21{h_insn_q[31]}}, h_insn_q[30:20]};
      end
      default: is_illegal = 1'b1;
    endcase
  end

  // Source indices come from H only, so a held or empty slot never raises a false hazard.
  assign de_rs1 = (reset_n && h_valid_q && use_rs1) ? h_insn_q[19:15] : 5'd0;
  assign de_rs2 = (reset_n && h_valid_q && use_rs2) ? h_insn_q[24:20] : 5'd0;

  always_comb begin
    dec           = '0;
    dec.pc        = h_pc_q;
    dec.rd        = use_rd ? h_insn_q[11:7] : 5'd0;
    dec.imm       = imm;
    dec.opcode    = opc;
    dec.funct3    = h_insn_q[14:12];
    dec.funct7b5  = h_insn_q[30];
    dec.mem_read  = is_load;
    dec.mem_write = is_store;
    dec.reg_write = use_rd;
    dec.illegal   = is_illegal;

    if (de_rs1 == 5'd0) begin
      dec.op1 = 32'h0;
    end else if (fwd_rs1[FwdEx]) begin
      dec.op1 = ex_fwd_data;
    end else if (fwd_rs1[FwdMem]) begin
      dec.op1 = mem_fwd_data;
    end else begin
      dec.op1 = rf_rdata1;
    end

    if (de_rs2 == 5'd0) begin
      dec.op2 = 32'h0;
    end else if (fwd_rs2[FwdEx]) begin
      dec.op2 = ex_fwd_data;
    end else if (fwd_rs2[FwdMem]) begin
      dec.op2 = mem_fwd_data;
    end else begin
      dec.op2 = rf_rdata2;
    end
  end

  assign out_free       = !o_valid_q || ex_ready;
  assign advance        = h_valid_q && !fwd_stall && out_free;
  assign fetch.de_ready = !reset_n || !h_valid_q || advance;
  assign accept         = fetch.if_valid && fetch.de_ready;

  always_comb begin
    h_valid_d = h_valid_q;
    h_pc_d    = h_pc_q;
    h_insn_d  = h_insn_q;
    o_valid_d = o_valid_q;
    o_d       = o_q;
    if (flush) begin
      // Redirect kills both slots and drops any beat arriving this cycle.
      h_valid_d = 1'b0;
      o_valid_d = 1'b0;
    end else begin
      if (accept) begin
        h_valid_d = 1'b1;
        h_pc_d    = fetch.if_pc;
        h_insn_d  = fetch.if_insn;
      end else if (advance) begin
        h_valid_d = 1'b0;
      end

      if (advance) begin
        o_valid_d = 1'b1;
        o_d       = dec;
      end else if (out_free) begin
        o_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_valid_q <= 1'b0;
      h_pc_q    <= 32'h0;
      h_insn_q  <= 32'h0;
      o_valid_q <= 1'b0;
      o_q       <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_pc_q    <= h_pc_d;
      h_insn_q  <= h_insn_d;
      o_valid_q <= o_valid_d;
      o_q       <= o_d;
    end
  end

  assign ex_valid_o   = o_valid_q;
  assign ex_pc        = o_q.pc;
  assign ex_rd        = o_q.rd;
  assign ex_op1       = o_q.op1;
  assign ex_op2       = o_q.op2;
  assign ex_imm       = o_q.imm;
  assign ex_opcode    = o_q.opcode;
  assign ex_funct3    = o_q.funct3;
  assign ex_funct7b5  = o_q.funct7b5;
  assign ex_mem_read  = o_q.mem_read;
  assign ex_mem_write = o_q.mem_write;
  assign ex_reg_write = o_q.reg_write;
  assign ex_illegal   = o_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, corner-case sequences, then random
// traffic checked cycle by cycle against a transaction-level reference.
module tb_decode_stage;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        ill;
  } out_t;

  typedef struct {
    logic [31:0] insn, rf1, rf2;
    logic [1:0]  f1, f2;
    logic [31:0] exd, memd;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] op1, op2, imm;
    logic        rw, mr, mw, ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  de_rs1, de_rs2;
  logic [31:0] rf_rdata1, rf_rdata2, ex_fwd_data, mem_fwd_data;
  logic        fwd_stall, ex_ready, flush;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic        ex_valid_o;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;

  decode_stage_if fif ();

  decode_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch        (fif),
    .de_rs1       (de_rs1),
    .de_rs2       (de_rs2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .fwd_stall    (fwd_stall),
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .ex_fwd_data  (ex_fwd_data),
    .mem_fwd_data (mem_fwd_data),
    .ex_ready     (ex_ready),
    .flush        (flush),
    .ex_valid_o   (ex_valid_o),
    .ex_pc        (ex_pc),
    .ex_rd        (ex_rd),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_imm       (ex_imm),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct7b5  (ex_funct7b5),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t       vt [12];
  logic [6:0] legal_ops [11];

  // Reference state: what H and O must hold, in transaction terms.
  logic        m_hv;
  logic [31:0] m_hpc, m_hinsn;
  out_t        m_o;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t dut_out();
    out_t r;
    r.v = ex_valid_o;      r.pc = ex_pc;        r.rd = ex_rd;
    r.op1 = ex_op1;        r.op2 = ex_op2;      r.imm = ex_imm;
    r.opc = ex_opcode;     r.f3 = ex_funct3;    r.f7b5 = ex_funct7b5;
    r.mr = ex_mem_read;    r.mw = ex_mem_write; r.rw = ex_reg_write;
    r.ill = ex_illegal;
    return r;
  endfunction

  function automatic logic [4:0] ref_rs1(input logic [31:0] insn);
    if (insn[6:0] inside {OpcJalr, OpcBranch, OpcLoad, OpcStore, OpcOpImm, OpcOp})
      return insn[19:15];
    return 5'd0;
  endfunction

  function automatic logic [4:0] ref_rs2(input logic [31:0] insn);
    if (insn[6:0] inside {OpcBranch, OpcStore, OpcOp}) return insn[24:20];
    return 5'd0;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] insn);
    logic [6:0] op;
    op = insn[6:0];
    if (op inside {OpcJalr, OpcLoad, OpcOpImm, OpcFence, OpcSystem})
      return 32'($signed(insn[31:20]));
    if (op == OpcStore) return 32'($signed({insn[31:25], insn[11:7]}));
    if (op == OpcBranch)
      return 32'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
    if (op inside {OpcLui, OpcAuipc}) return insn & 32'hFFFF_F000;
    if (op == OpcJal)
      return 32'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [1:0] f,
                                              input logic [31:0] rf, exd, memd);
    if (idx == 5'd0) return 32'h0;
    if (f[1]) return exd;
    if (f[0]) return memd;
    return rf;
  endfunction

  function automatic out_t ref_issue(input logic [31:0] pc, insn, rf1, rf2,
                                     input logic [1:0] f1, f2, input logic [31:0] exd, memd);
    out_t  r;
    logic  writes;
    writes = insn[6:0] inside {OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcLoad, OpcOpImm, OpcOp};
    r.v    = 1'b1;
    r.pc   = pc;
    r.rd   = writes ? insn[11:7] : 5'd0;
    r.rw   = writes;
    r.mr   = (insn[6:0] == OpcLoad);
    r.mw   = (insn[6:0] == OpcStore);
    r.ill  = !(insn[6:0] inside {OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcBranch, OpcLoad,
                                 OpcStore, OpcOpImm, OpcOp, OpcFence, OpcSystem});
    r.imm  = ref_imm(insn);
    r.op1  = ref_operand(ref_rs1(insn), f1, rf1, exd, memd);
    r.op2  = ref_operand(ref_rs2(insn), f2, rf2, exd, memd);
    r.opc  = insn[6:0];
    r.f3   = insn[14:12];
    r.f7b5 = insn[30];
    return r;
  endfunction

  task automatic idle_inputs();
    fif.if_valid = 1'b0; fif.if_pc = 32'h0; fif.if_insn = 32'h0;
    rf_rdata1 = 32'h0; rf_rdata2 = 32'h0; ex_fwd_data = 32'h0; mem_fwd_data = 32'h0;
    fwd_rs1 = 2'b00; fwd_rs2 = 2'b00; fwd_stall = 1'b0; ex_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [31:0] pc, input logic [31:0] insn);
    fif.if_valid = v; fif.if_pc = pc; fif.if_insn = insn;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    legal_ops = '{OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcBranch, OpcLoad,
                  OpcStore, OpcOpImm, OpcOp, OpcFence, OpcSystem};
    //          insn          rf1      rf2     f1     f2     exd      memd  rs1 rs2 rd  op1
    //          op2      imm            rw mr mw ill
    vt[0]  = '{32'hFFC08293, 32'd10, 32'h55, 2'b00, 2'b00, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5,
               32'd10, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h002081B3, 32'h11, 32'h22, 2'b10, 2'b01, 32'd7, 32'd9, 5'd1, 5'd2, 5'd3,
               32'd7, 32'd9, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{32'h00000000, 32'd5, 32'd6, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{32'h00812303, 32'h1234, 32'h9, 2'b00, 2'b00, 32'h0, 32'h0, 5'd2, 5'd0, 5'd6,
               32'h1234, 32'h0, 32'd8, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{32'hFE71AC23, 32'h100, 32'hAB, 2'b00, 2'b00, 32'h0, 32'h0, 5'd3, 5'd7, 5'd0,
               32'h100, 32'hAB, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{32'hFE2088E3, 32'd3, 32'd4, 2'b00, 2'b00, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0,
               32'd3, 32'd4, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h12345537, 32'd77, 32'd78, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd10,
               32'h0, 32'h0, 32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h008000EF, 32'd1, 32'd2, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1,
               32'h0, 32'h0, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h00008067, 32'h200, 32'd2, 2'b00, 2'b00, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0,
               32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'hFFFFF117, 32'd1, 32'd2, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2,
               32'h0, 32'h0, 32'hFFFF_F000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'h002001B3, 32'd1, 32'd5, 2'b10, 2'b00, 32'hDEAD, 32'h0, 5'd0, 5'd2, 5'd3,
               32'h0, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h002081B3, 32'd1, 32'd2, 2'b11, 2'b11, 32'd7, 32'd9, 5'd1, 5'd2, 5'd3,
               32'd7, 32'd7, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset behaviour.
    reset_n = 1'b0;
    idle_inputs();
    beat(1'b1, 32'h40, 32'h002081B3);
    #2;
    chk("rst_during_ready_rs", {fif.de_ready, de_rs1, de_rs2}, {1'b1, 5'd0, 5'd0});
    tick();
    chk("rst_edge_ready_rs", {fif.de_ready, de_rs1, de_rs2}, {1'b1, 5'd0, 5'd0});
    chk("rst_out_zero", dut_out(), out_t'(0));
    reset_n = 1'b1;
    beat(1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_after_ready_rs", {fif.de_ready, de_rs1, de_rs2}, {1'b1, 5'd0, 5'd0});
    chk("rst_after_out_zero", dut_out(), out_t'(0));

    // Directed decode vectors, two-cycle latency each.
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      beat(1'b1, 32'h100 + 32'(i * 4), vt[i].insn);
      tick();
      beat(1'b0, 32'h0, 32'h0);
      rf_rdata1 = vt[i].rf1; rf_rdata2 = vt[i].rf2;
      fwd_rs1 = vt[i].f1; fwd_rs2 = vt[i].f2;
      ex_fwd_data = vt[i].exd; mem_fwd_data = vt[i].memd;
      #1;
      chk($sformatf("vec%0d_rs", i), {de_rs1, de_rs2}, {vt[i].rs1, vt[i].rs2});
      tick();
      #1;
      chk($sformatf("vec%0d_out", i),
          {ex_valid_o, ex_rd, ex_op1, ex_op2, ex_imm, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_illegal},
          {1'b1, vt[i].rd, vt[i].op1, vt[i].op2, vt[i].imm, vt[i].rw, vt[i].mr,
           vt[i].mw, vt[i].ill});
      chk($sformatf("vec%0d_pc", i), ex_pc, 32'h100 + 32'(i * 4));
    end

    // Forwarding stall for two cycles: bubbles, then the held instruction issues.
    idle_inputs();
    beat(1'b1, 32'h400, 32'hFFC08293);
    tick();
    fwd_stall = 1'b1;
    beat(1'b1, 32'h404, 32'h002081B3);
    #1;
    chk("stall_c1_ready", fif.de_ready, 1'b0);
    tick();
    #1;
    chk("stall_c1_bubble", {ex_valid_o, fif.de_ready}, {1'b0, 1'b0});
    tick();
    #1;
    chk("stall_c2_bubble", {ex_valid_o, fif.de_ready}, {1'b0, 1'b0});
    fwd_stall = 1'b0;
    #1;
    chk("stall_release_ready", fif.de_ready, 1'b1);
    tick();
    beat(1'b0, 32'h0, 32'h0);
    #1;
    chk("stall_issue_a", {ex_valid_o, ex_pc}, {1'b1, 32'h400});
    tick();
    #1;
    chk("stall_issue_b", {ex_valid_o, ex_pc}, {1'b1, 32'h404});

    // Execute backpressure with both registers full.
    beat(1'b1, 32'h200, 32'hFFC08293);
    tick();
    beat(1'b1, 32'h204, 32'h002081B3);
    tick();
    ex_ready = 1'b0;
    beat(1'b1, 32'h208, 32'h12345537);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_hold", k), {ex_valid_o, ex_pc, ex_rd, ex_imm, fif.de_ready},
          {1'b1, 32'h200, 5'd5, 32'hFFFF_FFFC, 1'b0});
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", fif.de_ready, 1'b1);
    tick();
    beat(1'b0, 32'h0, 32'h0);
    #1;
    chk("bp_next1", {ex_valid_o, ex_pc, ex_rd}, {1'b1, 32'h204, 5'd3});
    tick();
    #1;
    chk("bp_next2", {ex_valid_o, ex_pc, ex_rd}, {1'b1, 32'h208, 5'd10});
    tick();
    #1;
    chk("bp_drained", ex_valid_o, 1'b0);

    // Flush concurrent with a fetch beat and an advance.
    beat(1'b1, 32'h300, 32'h002081B3);
    tick();
    beat(1'b1, 32'h304, 32'hFFC08293);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    beat(1'b0, 32'h0, 32'h0);
    #1;
    chk("flush_empty", {ex_valid_o, fif.de_ready, de_rs1, de_rs2},
        {1'b0, 1'b1, 5'd0, 5'd0});
    beat(1'b1, 32'h308, 32'hFFC08293);
    rf_rdata1 = 32'd10;
    tick();
    beat(1'b0, 32'h0, 32'h0);
    tick();
    #1;
    chk("flush_after", {ex_valid_o, ex_pc, ex_rd, ex_op1}, {1'b1, 32'h308, 5'd5, 32'd10});

    // Randomised traffic against the reference.
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_hv = 1'b0; m_hpc = 32'h0; m_hinsn = 32'h0; m_o = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      logic [4:0]  e1, e2;
      logic        adv, erdy;
      out_t        issued;
      r = $urandom();
      case ($urandom_range(0, 3))
        0:       fif.if_insn = vt[$urandom_range(0, 11)].insn;
        1, 2:    fif.if_insn = {r[31:7], legal_ops[$urandom_range(0, 10)]};
        default: fif.if_insn = r;
      endcase
      fif.if_valid = ($urandom_range(0, 3) != 0);
      fif.if_pc    = $urandom() & 32'hFFFF_FFFC;
      rf_rdata1    = $urandom();
      rf_rdata2    = $urandom();
      ex_fwd_data  = $urandom();
      mem_fwd_data = $urandom();
      fwd_rs1      = 2'($urandom_range(0, 3));
      fwd_rs2      = 2'($urandom_range(0, 3));
      fwd_stall    = ($urandom_range(0, 3) == 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      reset_n      = ($urandom_range(0, 49) != 0);
      #1;
      e1     = (m_hv && reset_n) ? ref_rs1(m_hinsn) : 5'd0;
      e2     = (m_hv && reset_n) ? ref_rs2(m_hinsn) : 5'd0;
      adv    = m_hv && !fwd_stall && (!m_o.v || ex_ready);
      erdy   = !reset_n || !m_hv || adv;
      issued = ref_issue(m_hpc, m_hinsn, rf_rdata1, rf_rdata2, fwd_rs1, fwd_rs2,
                         ex_fwd_data, mem_fwd_data);
      chk($sformatf("rand%0d_ready_rs", n), {fif.de_ready, de_rs1, de_rs2}, {erdy, e1, e2});
      chk($sformatf("rand%0d_out", n), dut_out(), m_o);
      @(posedge clk);
      if (!reset_n) begin
        m_hv = 1'b0; m_hpc = 32'h0; m_hinsn = 32'h0; m_o = '0;
      end else if (flush) begin
        m_hv = 1'b0; m_o.v = 1'b0;
      end else begin
        if (adv) m_o = issued;
        else if (!m_o.v || ex_ready) m_o.v = 1'b0;
        if (fif.if_valid && erdy) begin
          m_hv = 1'b1; m_hpc = fif.if_pc; m_hinsn = fif.if_insn;
        end else if (adv) begin
          m_hv = 1'b0;
        end
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 if_valid  in  1  fetch presents an instruction.
REQ-004 if_pc, if_insn  in  32 each  fetched PC and instruction word.
REQ-005 de_ready  out  1  decode accepts the fetch beat this cycle.
REQ-006 de_rs1, de_rs2  out  5 each  source indices to forward unit and register file.
REQ-007 rf_rdata1, rf_rdata2  in  32 each  register-file read data for de_rs1/de_rs2.
REQ-008 fwd_stall  in  1; fwd_rs1, fwd_rs2  in  fwd_type_t (bits ex, mem)  forwarding controls.
REQ-009 ex_fwd_data, mem_fwd_data  in  32 each  forwarded results from execute and mem.
REQ-010 ex_ready  in  1  execute accepts the output register this cycle.
REQ-011 flush  in  1  redirect; kill all instructions held in decode.
REQ-012 ex_valid_o  out  1; ex_pc  out  32; ex_rd  out  5; ex_op1, ex_op2, ex_imm  out  32 each; ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1; ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal  out  1 each  execute payload.

Function
REQ-013 Two registers: holding register H (h_valid, h_pc, h_insn) and output register O (drives ex_* outputs).
REQ-014 Decode of H is combinational; de_rs1/de_rs2 derive from H only, never from if_insn.
REQ-015 de_rs1 = insn[19:15] for opcodes JALR, BRANCH, LOAD, STORE, OP-IMM, OP; otherwise 0.
REQ-016 de_rs2 = insn[24:20] for BRANCH, STORE, OP; otherwise 0.
REQ-017 Both de_rs1 and de_rs2 are 0 when h_valid=0.
REQ-018 Operand select per source: fwd.ex=1 -> ex_fwd_data; else fwd.mem=1 -> mem_fwd_data; else rf_rdata; index 0 -> 32'h0 regardless.
REQ-019 Immediate generated per format I/S/B/U/J, sign-extended from insn[31]; R-type -> 0.
REQ-020 rd = insn[11:7] and reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; otherwise rd=0 and reg_write=0.
REQ-021 mem_read=1 only for LOAD; mem_write=1 only for STORE.
REQ-022 Opcode outside the RV32I base set: illegal=1, reg_write/mem_read/mem_write=0, rs1/rs2=0.
REQ-023 out_free = !ex_valid_o | ex_ready.
REQ-024 advance = h_valid & !fwd_stall & out_free.
REQ-025 de_ready = !h_valid | advance (combinational).
REQ-026 On advance, O loads the decoded H contents and ex_valid_o=1.
REQ-027 If out_free and not advance, ex_valid_o clears next cycle (bubble inserted).
REQ-028 If !out_free, O holds all fields unchanged.
REQ-029 On if_valid & de_ready, H loads if_pc/if_insn with h_valid=1; else on advance h_valid clears; else H holds.
REQ-030 fwd_stall holds H and blocks advance; O still drains/bubbles per REQ-027.
REQ-031 flush=1 overrides everything: next cycle h_valid=0 and ex_valid_o=0, any concurrent fetch beat discarded.
REQ-032 Pipeline latency if_valid -> ex_valid_o = 2 cycles with no stall.
REQ-033 Throughput 1 instruction/cycle when fwd_stall=0 and ex_ready=1.

Reset
REQ-034 reset_n=0 at a clock edge: h_valid=0, ex_valid_o=0, all ex_* payload fields 0; reset has priority over flush and loads.
REQ-035 During and the cycle after reset, de_ready=1 and de_rs1=de_rs2=0.

Verification
REQ-036 ADDI x5,x1,-4 (0xFFC08293) at pc 0x100, rf_rdata1=10, no forwarding -> 2 cycles later ex_valid_o=1, ex_rd=5, ex_op1=10, ex_imm=0xFFFFFFFC, ex_reg_write=1.
REQ-037 ADD x3,x1,x2 with fwd_rs1.ex=1, ex_fwd_data=7, fwd_rs2.mem=1, mem_fwd_data=9 -> ex_op1=7, ex_op2=9.
REQ-038 fwd_stall=1 for 2 cycles on held instruction -> de_ready=0, 2 bubbles (ex_valid_o=0), H instruction issued on the cycle after stall drops.
REQ-039 ex_ready=0 for 3 cycles with O and H full -> O fields stable, de_ready=0, no instruction lost or duplicated.
REQ-040 flush concurrent with if_valid and advance -> next cycle h_valid=0, ex_valid_o=0; following beat decodes normally.
REQ-041 Opcode 7'b0000000 -> ex_illegal=1, ex_reg_write=0, de_rs1=de_rs2=0 (no false stall).
